// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution for the instruction sequencer.
// Runs FETCH/EXEC/HALTED, tracks the carry flag and produces link address/strobe.
module pc_branch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              ex_stall,
  input  logic              unconditional,
  input  logic [2:0]        conditional,
  input  logic              AdSel,
  input  logic              DataPCSel,
  input  logic              halt,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] offset,
  input  logic              carry_we,
  input  logic              carry_in,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              link_we,
  output logic              exec_valid,
  output logic              branch_taken,
  output logic              carry,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_carry;

  logic              w_complete;
  logic              w_cond;
  logic              w_taken;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_target;

  assign w_complete = (r_state == ST_EXEC) && !ex_stall;

  // Carry-based codes see the flag as it stood before this cycle's update.
  always_comb begin
    w_cond = 1'b0;
    case (conditional)
      3'b001:  w_cond = rs_val[ADDR_W-1];
      3'b010:  w_cond = (rs_val == '0);
      3'b011:  w_cond = (rs_val != '0);
      3'b100:  w_cond = r_carry;
      3'b101:  w_cond = ~r_carry;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken    = unconditional | w_cond;
  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  assign w_target   = AdSel ? rs_val : (w_pc_plus4 + (offset << 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ack) r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!ex_stall) begin
            if (carry_we) r_carry <= carry_in;
            if (halt) begin
              r_state <= ST_HALTED;
            end else begin
              r_pc    <= w_taken ? w_target : w_pc_plus4;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

  assign imem_req     = (r_state == ST_FETCH);
  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign link_addr    = w_pc_plus4;
  assign exec_valid   = (r_state == ST_EXEC);
  assign halted       = (r_state == ST_HALTED);
  assign carry        = r_carry;
  assign branch_taken = w_complete & w_taken & ~halt;
  assign link_we      = w_complete & DataPCSel & ~halt;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomized scoreboard bench for pc_branch_unit: a driver issues instructions and
// queues spec-derived expectations; a negedge monitor pops and compares them.
module tb_pc_branch_unit;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic          ex_stall;
  logic          unconditional;
  logic [2:0]    conditional;
  logic          AdSel;
  logic          DataPCSel;
  logic          halt;
  logic [AW-1:0] rs_val;
  logic [AW-1:0] offset;
  logic          carry_we;
  logic          carry_in;
  logic [AW-1:0] pc;
  logic [AW-1:0] link_addr;
  logic          link_we;
  logic          exec_valid;
  logic          branch_taken;
  logic          carry;
  logic          halted;

  pc_branch_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .ex_stall(ex_stall), .unconditional(unconditional),
    .conditional(conditional), .AdSel(AdSel), .DataPCSel(DataPCSel), .halt(halt),
    .rs_val(rs_val), .offset(offset), .carry_we(carry_we), .carry_in(carry_in),
    .pc(pc), .link_addr(link_addr), .link_we(link_we), .exec_valid(exec_valid),
    .branch_taken(branch_taken), .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic          bt;
    logic          lwe;
    logic [AW-1:0] la;
    logic [AW-1:0] npc;
    logic          carry;
    logic          hlt;
  } exec_t;

  exec_t         exq[$];
  logic [AW-1:0] fq[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  // Reference architectural state, advanced one instruction at a time.
  logic [AW-1:0] m_pc;
  logic          m_carry;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor
  bit            pend = 1'b0;
  exec_t         pend_rec;
  exec_t         mon_e;
  bit            mh = 1'b0;
  logic [AW-1:0] mh_pc;
  logic          mh_carry;

  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      mh   = 1'b0;
    end else begin
      if (pend) begin
        chk("next_pc", pc, pend_rec.npc);
        chk("carry_after", {31'd0, carry}, {31'd0, pend_rec.carry});
        chk("halted_after", {31'd0, halted}, {31'd0, pend_rec.hlt});
        pend = 1'b0;
        if (pend_rec.hlt) begin
          mh       = 1'b1;
          mh_pc    = pend_rec.npc;
          mh_carry = pend_rec.carry;
        end
      end else if (mh) begin
        chk("halt_pc", pc, mh_pc);
        chk("halt_carry", {31'd0, carry}, {31'd0, mh_carry});
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_flag", {31'd0, halted}, 32'd1);
      end
      if (imem_req) begin
        chk("fetch_exec_valid", {31'd0, exec_valid}, 32'd0);
        chk("fetch_link_we", {31'd0, link_we}, 32'd0);
        chk("fetch_bt", {31'd0, branch_taken}, 32'd0);
        if (fq.size() > 0) begin
          chk("imem_addr", imem_addr, fq[0]);
          if (imem_ack) void'(fq.pop_front());
        end
      end
      if (exec_valid) begin
        if (ex_stall) begin
          chk("stall_bt", {31'd0, branch_taken}, 32'd0);
          chk("stall_link_we", {31'd0, link_we}, 32'd0);
        end else if (exq.size() > 0) begin
          mon_e = exq.pop_front();
          chk("exec_pc", pc, mon_e.pc);
          chk("branch_taken", {31'd0, branch_taken}, {31'd0, mon_e.bt});
          chk("link_we", {31'd0, link_we}, {31'd0, mon_e.lwe});
          if (mon_e.lwe) chk("link_addr", link_addr, mon_e.la);
          pend     = 1'b1;
          pend_rec = mon_e;
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL exec_unexpected: completing EXEC with empty scoreboard at %0t", $time);
        end
      end
    end
  end

  // Driver
  task automatic noise();
    unconditional = 1'($urandom);
    conditional   = 3'($urandom);
    AdSel         = 1'($urandom);
    DataPCSel     = 1'($urandom);
    halt          = 1'($urandom);
    rs_val        = $urandom;
    offset        = $urandom;
    carry_we      = 1'($urandom);
    carry_in      = 1'($urandom);
    ex_stall      = 1'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int waits);
    repeat (waits) begin
      imem_ack = 1'b0;
      noise();
      step();
    end
    imem_ack = 1'b1;
    noise();
    step();
    imem_ack = 1'b0;
  endtask

  task automatic issue(input logic unc, input logic [2:0] cond, input logic ads,
                       input logic dps, input logic hlt, input logic [AW-1:0] rs,
                       input logic [AW-1:0] off, input logic cwe, input logic cin,
                       input int aw, input int st);
    exec_t e;
    logic  taken;
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    fq.push_back(m_pc);
    do_fetch(aw);
    chk("enter_exec", {31'd0, exec_valid}, 32'd1);
    unconditional = unc;
    conditional   = cond;
    AdSel         = ads;
    DataPCSel     = dps;
    halt          = hlt;
    rs_val        = rs;
    offset        = off;
    carry_we      = cwe;
    repeat (st) begin
      ex_stall = 1'b1;
      carry_in = 1'($urandom);
      step();
    end
    ex_stall = 1'b0;
    carry_in = cin;
    taken = unc || (cond == 3'd1 && rs[AW-1]) || (cond == 3'd2 && rs == 0) ||
            (cond == 3'd3 && rs != 0) || (cond == 3'd4 && m_carry) ||
            (cond == 3'd5 && !m_carry);
    e.pc    = m_pc;
    e.bt    = taken && !hlt;
    e.lwe   = dps && !hlt;
    e.la    = m_pc + 4;
    e.hlt   = hlt;
    e.carry = cwe ? cin : m_carry;
    if (hlt)        e.npc = m_pc;
    else if (!taken) e.npc = m_pc + 4;
    else if (ads)   e.npc = rs;
    else            e.npc = m_pc + 4 + off * 4;
    exq.push_back(e);
    m_pc    = e.npc;
    m_carry = e.carry;
    step();
    noise();
  endtask

  task automatic plain(input int aw, input int st);
    issue(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, aw, st);
  endtask

  task automatic jump(input logic [AW-1:0] tgt);
    issue(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, tgt, '0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_exec_valid", {31'd0, exec_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    step();
    reset   = 1'b0;
    m_pc    = '0;
    m_carry = 1'b0;
    fq.delete();
    exq.delete();
  endtask

  initial begin
    logic [AW-1:0] rs;
    reset    = 1'b1;
    imem_ack = 1'b0;
    noise();
    m_pc    = '0;
    m_carry = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_pc", pc, 32'd0);
    chk("init_carry", {31'd0, carry}, 32'd0);
    reset = 1'b0;

    repeat (4) plain(0, 0);
    chk("seq_pc", pc, 32'h10);

    issue(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3, 1'b0, 1'b0, 0, 0);
    chk("bz_taken_pc", pc, 32'h20);
    jump(32'h10);
    issue(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 32'd5, 32'd3, 1'b0, 1'b0, 0, 0);
    chk("bz_not_taken_pc", pc, 32'h14);
    issue(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd3, 1'b0, 1'b0, 0, 0);
    chk("bltz_pc", pc, 32'h24);
    issue(1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3, 1'b0, 1'b0, 0, 0);
    chk("bnz_pc", pc, 32'h28);

    issue(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 0, 0);
    chk("carry_set", {31'd0, carry}, 32'd1);
    jump(32'h40);
    issue(1'b0, 3'd4, 1'b0, 1'b0, 1'b0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0);
    chk("bcy_pc", pc, 32'h40);
    issue(1'b0, 3'd5, 1'b0, 1'b0, 1'b0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0);
    chk("bncy_pc", pc, 32'h44);
    issue(1'b0, 3'd4, 1'b0, 1'b0, 1'b0, '0, 32'd4, 1'b1, 1'b0, 0, 0);
    chk("bcy_old_carry_pc", pc, 32'h58);
    issue(1'b0, 3'd4, 1'b0, 1'b0, 1'b0, '0, 32'd4, 1'b0, 1'b0, 0, 0);
    chk("bcy_cleared_pc", pc, 32'h5C);

    jump(32'h100);
    chk("br_pc", pc, 32'h100);
    jump(32'h8);
    issue(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, '0, 32'd2, 1'b0, 1'b0, 3, 2);
    chk("bl_pc", pc, 32'h14);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = '0;
        1:       rs = 32'h8000_0000 | $urandom;
        default: rs = $urandom;
      endcase
      issue(1'($urandom_range(0, 3) == 0), 3'($urandom), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 3) == 0), 1'b0, rs,
            32'($urandom_range(0, 64)) - 32'd32, 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    jump(32'h200);
    fq.push_back(m_pc);
    do_fetch(1);
    ex_stall = 1'b1;
    step();
    do_reset();
    plain(0, 0);
    chk("post_reset_pc", pc, 32'h4);

    jump(32'h24);
    issue(1'b1, 3'd0, 1'b0, 1'b1, 1'b1, '0, 32'd5, 1'b1, 1'b1, 0, 1);
    repeat (10) begin
      imem_ack = 1'($urandom);
      noise();
      step();
    end
    chk("halt_hold_pc", pc, 32'h24);
    chk("halt_hold_flag", {31'd0, halted}, 32'd1);
    do_reset();
    plain(0, 0);
    chk("after_halt_reset_pc", pc, 32'h4);

    step();
    chk("exq_drained", exq.size(), 32'd0);
    chk("fq_drained", fq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
